// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scanner for common-anode digits. Features: tear-free
// double-buffered load, leading-zero suppression, PWM dimming and an anode guard time.
module sevenseg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 65536,
  parameter int GUARD      = 2,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [4*NUM_DIGITS-1:0] DATA,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic [NUM_DIGITS-1:0]   BLANK,
  input  logic                    LOAD,
  input  logic                    LZS,
  input  logic [BRIGHT_W-1:0]     BRIGHT,
  output logic [6:0]              COUT,
  output logic                    DPOUT,
  output logic [NUM_DIGITS-1:0]   AOUT,
  output logic                    FRAME
);

  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] GUARD_CNT  = PW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
  } disp_t;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
  logic                  pending_q, pending_d;
  disp_t                 stage_q, stage_d;
  disp_t                 active_q, active_d;
  logic [NUM_DIGITS-1:0] aout_q, aout_d;
  logic [6:0]            cout_q, cout_d;
  logic                  dpout_q, dpout_d;
  logic                  wrap_q, wrap_d;
  logic                  frame_q, frame_d;

  logic                  slot_end, frame_wrap;
  logic [NUM_DIGITS-1:0] suppress, dark;
  logic                  chain;
  logic [3:0]            cur_nib;
  logic                  cur_dark, cur_en;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h18;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h27;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Scan timing and the staging/active double buffer.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    slot_end   = (presc_q == PRESC_LAST);
    frame_wrap = slot_end && (idx_q == IDX_LAST);
    presc_d    = slot_end ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    pwm_d      = pwm_q + 1'b1;

    stage_d    = stage_q;
    active_d   = active_q;
    pending_d  = pending_q;
    // Active swaps only at frame wrap, so a frame never shows mixed data; a load in
    // the wrap cycle itself stays pending for the following frame.
    if (frame_wrap && pending_q) begin
      active_d  = stage_q;
      pending_d = 1'b0;
    end
    if (LOAD) begin
      stage_d   = {DATA, DP, BLANK};
      pending_d = 1'b1;
    end
  end

  // Leading-zero suppression walks down from the most significant digit.
  always_comb begin
    suppress = '0;
    chain    = LZS;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      chain       = chain && (active_q.data[4*i +: 4] == 4'h0) && !active_q.dp[i];
      suppress[i] = chain;
    end
    dark = active_q.blank | suppress;
  end

  always_comb begin
    cur_nib  = active_q.data[4*idx_q +: 4];
    cur_dark = dark[idx_q];
    cur_en   = (presc_q >= GUARD_CNT) && (pwm_q <= BRIGHT) && !cur_dark;
    aout_d   = '1;
    if (cur_en) aout_d[idx_q] = 1'b0;
    cout_d   = cur_dark ? 7'h7F : seg7(cur_nib);
    dpout_d  = cur_dark | ~active_q.dp[idx_q];
    // Two stages so FRAME lines up with the first registered slot-0 output.
    wrap_d   = frame_wrap;
    frame_d  = wrap_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops see
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q   <= '0;
      idx_q     <= '0;
      pwm_q     <= '0;
      pending_q <= 1'b0;
      stage_q   <= '0;
      active_q  <= '0;
      aout_q    <= '1;
      cout_q    <= 7'h7F;
      dpout_q   <= 1'b1;
      wrap_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      pwm_q     <= pwm_d;
      pending_q <= pending_d;
      stage_q   <= stage_d;
      active_q  <= active_d;
      aout_q    <= aout_d;
      cout_q    <= cout_d;
      dpout_q   <= dpout_d;
      wrap_q    <= wrap_d;
      frame_q   <= frame_d;
    end
  end

  assign AOUT  = aout_q;
  assign COUT  = cout_q;
  assign DPOUT = dpout_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan: a DIV=8 instance for scan/load/LZS/reset checks
// and a DIV=64 instance for PWM duty counting.
module tb_sevenseg_scan;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] DATA;
  logic [3:0]  DP, BLANK;
  logic        LOAD, LZS;
  logic [3:0]  BRIGHT;

  logic [6:0]  COUT, cout_b;
  logic        DPOUT, dpout_b;
  logic [3:0]  AOUT, aout_b;
  logic        FRAME, frame_b;

  int errors = 0;
  int checks = 0;
  int fpos   = 0;

  always #5 CLK = ~CLK;

  sevenseg_scan #(.NUM_DIGITS(4), .DIV(8), .GUARD(1), .BRIGHT_W(4)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .DATA(DATA), .DP(DP), .BLANK(BLANK), .LOAD(LOAD),
    .LZS(LZS), .BRIGHT(BRIGHT), .COUT(COUT), .DPOUT(DPOUT), .AOUT(AOUT), .FRAME(FRAME)
  );

  sevenseg_scan #(.NUM_DIGITS(4), .DIV(64), .GUARD(2), .BRIGHT_W(4)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N), .DATA(DATA), .DP(DP), .BLANK(BLANK), .LOAD(LOAD),
    .LZS(LZS), .BRIGHT(BRIGHT), .COUT(cout_b), .DPOUT(dpout_b), .AOUT(aout_b), .FRAME(frame_b)
  );

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  task automatic wait_frame(input string name);
    bit found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (FRAME === 1'b1) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: FRAME got no pulse in 100 clks, required one", name);
    end
    fpos = 0;
  endtask

  // Checks n output cycles of the DIV=8 instance at frame position fpos onward;
  // optionally strobes LOAD during iteration load_at.
  task automatic check_cycles(input int n, input logic [15:0] data, input logic [3:0] dp,
                              input logic [3:0] dark, input string name, input int load_at,
                              input logic [15:0] ld_data, input logic [3:0] ld_dp,
                              input logic [3:0] ld_blank);
    logic [3:0]  one = 4'b0001;
    logic [12:0] got, exp;
    int slot, p;
    logic [3:0]  ea;
    logic [6:0]  ec;
    logic        ed;
    for (int i = 0; i < n; i++) begin
      slot = fpos / 8;
      p    = fpos % 8;
      ea   = (p >= 1 && !dark[slot]) ? ~(one << slot) : 4'hF;
      ec   = dark[slot] ? 7'h7F : seg(data[slot*4 +: 4]);
      ed   = dark[slot] ? 1'b1 : ~dp[slot];
      exp  = {fpos == 0, ed, ec, ea};
      got  = {FRAME, DPOUT, COUT, AOUT};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s fpos=%0d: got frame=%b dpout=%b cout=%h aout=%b, want frame=%b dpout=%b cout=%h aout=%b",
                 name, fpos, got[12], got[11], got[10:4], got[3:0], exp[12], exp[11], exp[10:4], exp[3:0]);
      end
      if (i == load_at) begin
        LOAD = 1'b1; DATA = ld_data; DP = ld_dp; BLANK = ld_blank;
      end else begin
        LOAD = 1'b0;
      end
      @(negedge CLK);
      fpos = (fpos + 1) % 32;
    end
    LOAD = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    logic [25:0] got;
    got = {AOUT, COUT, DPOUT, FRAME, aout_b, cout_b, dpout_b, frame_b};
    checks++;
    if (got !== {4'hF, 7'h7F, 1'b1, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s: got aout=%b cout=%h dpout=%b frame=%b (b: %b %h %b %b), want 1111 7f 1 0 on both",
               name, AOUT, COUT, DPOUT, FRAME, aout_b, cout_b, dpout_b, frame_b);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b1; DATA = '0; DP = '0; BLANK = '0; LOAD = 1'b0; LZS = 1'b0; BRIGHT = 4'hF;
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("reset_async");
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset_hold");
    RST_N = 1'b1;
  endtask

  task automatic test_basic_scan();
    @(negedge CLK);
    LOAD = 1'b1; DATA = 16'h1234; DP = 4'b0000; BLANK = 4'b0000;
    @(negedge CLK);
    LOAD = 1'b0;
    wait_frame("basic_sync");
    check_cycles(64, 16'h1234, 4'b0000, 4'b0000, "basic", -1, '0, '0, '0);
  endtask

  task automatic test_tear_free();
    check_cycles(32, 16'h1234, 4'b0000, 4'b0000, "tear_pre", 0, 16'hAAAA, 4'b0000, 4'b0000);
    check_cycles(19, 16'hAAAA, 4'b0000, 4'b0000, "tear_a_head", 18, 16'h5555, 4'b0000, 4'b0000);
    check_cycles(13, 16'hAAAA, 4'b0000, 4'b0000, "tear_a_tail", -1, '0, '0, '0);
    check_cycles(32, 16'h5555, 4'b0000, 4'b0000, "tear_b", -1, '0, '0, '0);
  endtask

  task automatic test_back_to_back();
    check_cycles(30, 16'h5555, 4'b0000, 4'b0000, "b2b_stage", 10, 16'h6789, 4'b0000, 4'b0000);
    check_cycles(2, 16'h5555, 4'b0000, 4'b0000, "b2b_wrap", 0, 16'hABCD, 4'b0000, 4'b0000);
    check_cycles(32, 16'h6789, 4'b0000, 4'b0000, "b2b_old", -1, '0, '0, '0);
    check_cycles(32, 16'hABCD, 4'b0000, 4'b0000, "b2b_new", -1, '0, '0, '0);
  endtask

  task automatic test_lzs_blank();
    LZS = 1'b1;
    check_cycles(32, 16'hABCD, 4'b0000, 4'b0000, "lzs_pre", 0, 16'h0050, 4'b0000, 4'b0000);
    check_cycles(32, 16'h0050, 4'b0000, 4'b1100, "lzs_sup", 0, 16'h0050, 4'b1000, 4'b0000);
    check_cycles(32, 16'h0050, 4'b1000, 4'b0000, "lzs_dp", 0, 16'h0F00, 4'b0000, 4'b0010);
    check_cycles(32, 16'h0F00, 4'b0000, 4'b1010, "lzs_blank", -1, '0, '0, '0);
    LZS = 1'b0;
  endtask

  task automatic count_lit(output int lit, output int multi);
    int zeros;
    lit = 0;
    multi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge CLK);
      zeros = 0;
      for (int b = 0; b < 4; b++) if (aout_b[b] === 1'b0) zeros++;
      if (zeros >= 1) lit++;
      if (zeros > 1) multi++;
    end
  endtask

  task automatic test_brightness();
    int lit, multi;
    logic [3:0] levels [3] = '{4'h3, 4'h0, 4'hF};
    int         want   [3] = '{56, 12, 248};
    @(negedge CLK);
    LOAD = 1'b1; DATA = 16'h1234; DP = 4'b0000; BLANK = 4'b0000;
    @(negedge CLK);
    LOAD = 1'b0;
    repeat (600) @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      BRIGHT = levels[k];
      repeat (2) @(negedge CLK);
      count_lit(lit, multi);
      checks++;
      if (lit !== want[k]) begin
        errors++;
        $display("FAIL bright_%h: got %0d lit clks per frame, want %0d", levels[k], lit, want[k]);
      end
      checks++;
      if (multi !== 0) begin
        errors++;
        $display("FAIL onehot_%h: got %0d clks with >1 anode low, want 0", levels[k], multi);
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    int first = 0;
    BRIGHT = 4'hF;
    wait_frame("rst_sync");
    repeat (12) @(negedge CLK);
    fpos = 12;
    checks++;
    if ({AOUT, COUT} !== {4'b1101, 7'h30}) begin
      errors++;
      $display("FAIL rst_pre: got aout=%b cout=%h, want 1101 30", AOUT, COUT);
    end
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("rst_mid_async");
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst_mid_hold");
    RST_N = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        checks++;
        if ({AOUT, COUT} !== {4'hF, 7'h40}) begin
          errors++;
          $display("FAIL rst_first_guard: got aout=%b cout=%h, want 1111 40", AOUT, COUT);
        end
      end
      if (k == 2) begin
        checks++;
        if ({AOUT, COUT} !== {4'b1110, 7'h40}) begin
          errors++;
          $display("FAIL rst_first_lit: got aout=%b cout=%h, want 1110 40", AOUT, COUT);
        end
      end
      if (FRAME === 1'b1) begin
        first = k;
        break;
      end
    end
    checks++;
    if (first !== 33) begin
      errors++;
      $display("FAIL rst_first_frame: got FRAME first at clk %0d after release, want 33", first);
    end
    fpos = 0;
    check_cycles(32, 16'h0000, 4'b0000, 4'b0000, "rst_zero_data", -1, '0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_back_to_back();
    test_lzs_blank();
    test_brightness();
    test_reset_mid_slot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
